main_mul_seq: RTL and testbench

MAIN_MUL_SEQ -- requirements
Module: main_mul_seq

---
 rtl/main_mul_seq_if.sv | 24 ++
 rtl/main_mul_seq.sv | 179 +++++++++++++++++
 tb/tb_main_mul_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/main_mul_seq_if.sv
// Request/result bundle for the sequential binary32 multiplier.
// The master drives the operands and start; the slave returns the product and status.
interface main_mul_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] m;
    logic                  overflow;
    logic                  underflow;
    logic                  busy;
    logic                  done;

    modport master (
        output start, a, b,
        input  m, overflow, underflow, busy, done
    );

    modport slave (
        input  start, a, b,
        output m, overflow, underflow, busy, done
    );
endinterface

// File: rtl/main_mul_seq.sv
// Sequential IEEE-754 binary32 multiplier: 24-step shift-add significand product,
// round-to-nearest-even, flush-to-zero on denormal inputs and underflowing results.
module main_mul_seq #(
    parameter int DATA_WIDTH = 32  // only 32 (binary32) is supported
) (
    input  logic          clk,
    input  logic          rst,
    main_mul_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_NORM,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_m;
    logic                  r_ovf;
    logic                  r_unf;
    logic                  r_sign;
    logic signed [9:0]     r_exp;
    logic [47:0]           r_prod;
    logic [47:0]           r_mcand;
    logic [23:0]           r_mplier;
    logic [4:0]            r_cnt;

    logic [7:0]            w_ea;
    logic [7:0]            w_eb;
    logic [22:0]           w_fa;
    logic [22:0]           w_fb;
    logic                  w_a_zero, w_a_inf, w_a_nan;
    logic                  w_b_zero, w_b_inf, w_b_nan;
    logic                  w_special;
    logic                  w_sign;
    logic [DATA_WIDTH-1:0] w_special_m;

    logic                  w_p47;
    logic [22:0]           w_mant;
    logic                  w_guard;
    logic                  w_sticky;
    logic                  w_round_up;
    logic [23:0]           w_mant_rnd;
    logic                  w_carry;
    logic signed [9:0]     w_exp_fin;
    logic [DATA_WIDTH-1:0] w_norm_m;
    logic                  w_norm_ovf;
    logic                  w_norm_unf;

    // Operand classification; exp=0 counts as zero, which flushes denormals.
    assign w_ea      = r_a[30:23];
    assign w_eb      = r_b[30:23];
    assign w_fa      = r_a[22:0];
    assign w_fb      = r_b[22:0];
    assign w_a_zero  = (w_ea == 8'h00);
    assign w_b_zero  = (w_eb == 8'h00);
    assign w_a_inf   = (w_ea == 8'hFF) && (w_fa == 23'd0);
    assign w_b_inf   = (w_eb == 8'hFF) && (w_fb == 23'd0);
    assign w_a_nan   = (w_ea == 8'hFF) && (w_fa != 23'd0);
    assign w_b_nan   = (w_eb == 8'hFF) && (w_fb != 23'd0);
    assign w_special = w_a_zero || w_a_inf || w_a_nan || w_b_zero || w_b_inf || w_b_nan;
    assign w_sign    = r_a[31] ^ r_b[31];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_special_m = {w_sign, 31'd0};
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_inf) || (w_a_inf && w_b_zero)) begin
            w_special_m = 32'h7FC0_0000;
        end else if (w_a_inf || w_b_inf) begin
            w_special_m = {w_sign, 8'hFF, 23'd0};
        end
    end

    // Normalize: product of two [1,2) significands lies in [1,4).
    always_comb begin
        w_p47    = r_prod[47];
        w_mant   = r_prod[45:23];
        w_guard  = r_prod[22];
        w_sticky = |r_prod[21:0];
        if (w_p47) begin
            w_mant   = r_prod[46:24];
            w_guard  = r_prod[23];
            w_sticky = |r_prod[22:0];
        end
        w_round_up = w_guard & (w_sticky | w_mant[0]);
        w_mant_rnd = {1'b0, w_mant} + {23'd0, w_round_up};
        // A carry out means the significand rounded up to 2.0; fraction is already zero.
        w_carry    = w_mant_rnd[23];
        w_exp_fin  = r_exp + $signed({9'd0, w_p47}) + $signed({9'd0, w_carry});
        w_norm_ovf = 1'b0;
        w_norm_unf = 1'b0;
        w_norm_m   = {r_sign, w_exp_fin[7:0], w_mant_rnd[22:0]};
        if (w_exp_fin >= 10'sd255) begin
            w_norm_ovf = 1'b1;
            w_norm_m   = {r_sign, 8'hFF, 23'd0};
        end else if (w_exp_fin <= 10'sd0) begin
            w_norm_unf = 1'b1;
            w_norm_m   = {r_sign, 31'd0};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_nxt = S_UNPACK;
            S_UNPACK: w_state_nxt = w_special ? S_DONE : S_MULT;
            S_MULT:   if (r_cnt == 5'd23) w_state_nxt = S_NORM;
            S_NORM:   w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a <= bus.a;
                        r_b <= bus.b;
                    end
                end
                S_UNPACK: begin
                    r_sign   <= w_sign;
                    r_exp    <= $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;
                    r_mcand  <= {24'd0, 1'b1, w_fa};
                    r_mplier <= {1'b1, w_fb};
                    r_prod   <= '0;
                    r_cnt    <= '0;
                    if (w_special) begin
                        r_m   <= w_special_m;
                        r_ovf <= 1'b0;
                        r_unf <= 1'b0;
                    end
                end
                S_MULT: begin
                    if (r_mplier[0]) r_prod <= r_prod + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                end
                S_NORM: begin
                    r_m   <= w_norm_m;
                    r_ovf <= w_norm_ovf;
                    r_unf <= w_norm_unf;
                end
                default: ;
            endcase
        end
    end

    assign bus.m         = r_m;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
endmodule

// File: tb/tb_main_mul_seq.sv
// Self-checking bench for main_mul_seq: directed corner cases, back-to-back start,
// mid-operation reset and randomized operands against an integer-arithmetic float model.
module tb_main_mul_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    main_mul_seq_if #(.DATA_WIDTH(32)) bus ();

    main_mul_seq #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product of significands, rounded by remainder comparison.
    task automatic ref_mul(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] m, output logic ovf, output logic unf,
                           output logic special);
        int     ea, eb, e, sh;
        longint p, sig, rem, half;
        logic   s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        s      = a[31] ^ b[31];
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        ovf     = 1'b0;
        unf     = 1'b0;
        special = a_zero || b_zero || a_inf || b_inf || a_nan || b_nan;
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
            m = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            m = {s, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            m = {s, 31'd0};
        end else begin
            p  = longint'({9'd1, a[22:0]}) * longint'({9'd1, b[22:0]});
            e  = ea + eb - 127;
            sh = 23;
            if (p >= (64'sd1 <<< 47)) begin
                sh = 24;
                e  = e + 1;
            end
            sig  = p >>> sh;
            rem  = p - (sig <<< sh);
            half = 64'sd1 <<< (sh - 1);
            if (rem > half || (rem == half && sig[0])) sig = sig + 1;
            if (sig == (64'sd1 <<< 24)) begin
                sig = sig >>> 1;
                e   = e + 1;
            end
            if (e >= 255) begin
                m   = {s, 8'hFF, 23'd0};
                ovf = 1'b1;
            end else if (e <= 0) begin
                m   = {s, 31'd0};
                unf = 1'b1;
            end else begin
                m = {s, e[7:0], sig[22:0]};
            end
        end
    endtask

    // One transaction: start at edge E, then count edges until done, checking busy throughout.
    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b);
        logic [31:0] em;
        logic        eo, eu, esp;
        int          lat;
        logic        busy_ok;
        ref_mul(op_a, op_b, em, eo, eu, esp);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = op_a;
        bus.b     = op_b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        lat       = 0;
        busy_ok   = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, lat, esp ? 32'd1 : 32'd26);
        check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " m"}, bus.m, em);
        check({tag, " ovf"}, {31'd0, bus.overflow}, {31'd0, eo});
        check({tag, " unf"}, {31'd0, bus.underflow}, {31'd0, eu});
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: ;
            1: r[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            default: r[30:23] = 8'($urandom_range(64, 190));
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] a2, b2, em1, em2, m_held;
        logic        eo, eu, esp;
        int          k1, k2, n_done;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset m", bus.m, 32'd0);
        check("reset ovf", {31'd0, bus.overflow}, 32'd0);
        check("reset unf", {31'd0, bus.underflow}, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("1.5x2", 32'h3FC0_0000, 32'h4000_0000);
        check("1.5x2 exact", bus.m, 32'h4040_0000);
        run_op("-2x3", 32'hC000_0000, 32'h4040_0000);
        check("-2x3 exact", bus.m, 32'hC0C0_0000);
        run_op("rne", 32'h3F80_0001, 32'h3F80_0001);
        check("rne exact", bus.m, 32'h3F80_0002);
        run_op("0xinf", 32'h0000_0000, 32'h7F80_0000);
        check("0xinf exact", bus.m, 32'h7FC0_0000);
        run_op("infxneg1", 32'h7F80_0000, 32'hBF80_0000);
        check("infxneg1 exact", bus.m, 32'hFF80_0000);
        run_op("underflow", 32'h0080_0000, 32'h3F00_0000);
        check("underflow exact", {bus.m[31:1], bus.underflow}, 32'h0000_0001);
        run_op("overflow", 32'h7F00_0000, 32'h7F00_0000);
        check("overflow exact", {bus.m[31:1], bus.overflow}, {31'h3FC0_0000, 1'b1});

        // Outputs hold between operations.
        m_held = bus.m;
        repeat (3) @(posedge clk);
        #1;
        check("hold m", bus.m, 32'h7F80_0000);
        check("hold ovf", {31'd0, bus.overflow}, 32'd1);
        check("hold m stable", bus.m, m_held);

        // start held high: operands change while busy, second op picks them up only from IDLE.
        a2 = 32'h4120_0000;
        b2 = 32'hC2C8_0000;
        ref_mul(32'h3FC0_0000, 32'h4000_0000, em1, eo, eu, esp);
        ref_mul(a2, b2, em2, eo, eu, esp);
        k1 = 0;
        k2 = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h3FC0_0000;
        bus.b     = 32'h4000_0000;
        @(posedge clk);
        @(negedge clk);
        bus.a = a2;
        bus.b = b2;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (k1 == 0) begin
                    k1 = k;
                    check("b2b first m", bus.m, em1);
                end else begin
                    k2 = k;
                    check("b2b second m", bus.m, em2);
                    break;
                end
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b first latency", k1, 32'd26);
        check("b2b second latency", k2, 32'd54);
        repeat (2) @(posedge clk);
        #1;
        check("b2b idle", {31'd0, bus.busy}, 32'd0);

        // Reset during MULT after an overflow result was left on the outputs.
        run_op("pre-reset", 32'h7F00_0000, 32'h7F00_0000);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h3FC0_0000;
        bus.b     = 32'h4000_0000;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("mid-reset m", bus.m, 32'd0);
        check("mid-reset ovf", {31'd0, bus.overflow}, 32'd0);
        check("mid-reset unf", {31'd0, bus.underflow}, 32'd0);
        check("mid-reset busy", {31'd0, bus.busy}, 32'd0);
        check("mid-reset done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        n_done    = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        check("no done after abort", n_done, 32'd0);
        run_op("post-reset", 32'h3FC0_0000, 32'h4000_0000);
        check("post-reset exact", bus.m, 32'h4040_0000);

        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rand%0d", i), rand_operand(), rand_operand());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
